// File: rtl/l2_mem_ctrl_pkg.sv
// Shared definitions for the L2 miss controller: default widths, FSM state
// encoding and the word-offset width helper.
package l2_mem_ctrl_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_WORDS_PER_LINE = 4;

    // Width of the word index within a line; never narrower than one bit.
    function automatic int word_offset_w(input int words_per_line);
        return (words_per_line > 1) ? $clog2(words_per_line) : 1;
    endfunction

    localparam int WORD_OFFSET_W = word_offset_w(DEF_WORDS_PER_LINE);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WB_REQ   = 3'd1,
        ST_WB_GAP   = 3'd2,
        ST_FILL_REQ = 3'd3,
        ST_FILL_GAP = 3'd4,
        ST_RESP     = 3'd5
    } l2_state_e;

endpackage

// File: rtl/l2_mem_ctrl.sv
// L2 miss controller: optional dirty-victim write-back followed by a line fill,
// one memory word per handshake with a one-cycle gap between words.
module l2_mem_ctrl
    import l2_mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_evict,
    input  logic [ADDR_WIDTH-1:0]                cmd_fill_addr,
    input  logic [ADDR_WIDTH-1:0]                cmd_victim_addr,
    input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] cmd_victim_data,
    output logic                                 rsp_valid,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0]                l2_cache_addr,
    output logic [DATA_WIDTH-1:0]                l2_cache_data_in,
    input  logic [DATA_WIDTH-1:0]                l2_cache_data_out,
    output logic                                 l2_cache_read,
    output logic                                 l2_cache_write,
    input  logic                                 l2_cache_ready
);

    localparam int IDX_W      = word_offset_w(WORDS_PER_LINE);
    localparam int LINE_OFF_W = $clog2(WORDS_PER_LINE * DATA_WIDTH / 8);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK  =
        ~((ADDR_WIDTH'(1) << LINE_OFF_W) - ADDR_WIDTH'(1));

    typedef logic [WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] line_t;

    l2_state_e             state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] fill_base_q, fill_base_d;
    logic [ADDR_WIDTH-1:0] victim_base_q, victim_base_d;
    line_t                 victim_data_q, victim_data_d;
    line_t                 line_q, line_d;
    line_t                 rsp_data_q, rsp_data_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    // Next state, beat index, captured command and line-buffer updates.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        fill_base_d   = fill_base_q;
        victim_base_d = victim_base_q;
        victim_data_d = victim_data_q;
        line_d        = line_q;
        rsp_data_d    = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    fill_base_d   = cmd_fill_addr & BASE_MASK;
                    victim_base_d = cmd_victim_addr & BASE_MASK;
                    victim_data_d = cmd_victim_data;
                    idx_d         = '0;
                    state_d       = cmd_evict ? ST_WB_REQ : ST_FILL_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB_REQ: begin
                if (l2_cache_ready) begin
                    if (idx_q == LAST_IDX) begin
                        // Last victim word goes straight into the fill, no gap.
                        state_d = ST_FILL_REQ;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_WB_GAP;
                    end
                end else begin
                    state_d = ST_WB_REQ;
                end
            end
            ST_WB_GAP: begin
                state_d = ST_WB_REQ;
                idx_d   = idx_q + IDX_W'(1);
            end
            ST_FILL_REQ: begin
                if (l2_cache_ready) begin
                    line_d[idx_q] = l2_cache_data_out;
                    if (idx_q == LAST_IDX) begin
                        state_d    = ST_RESP;
                        rsp_data_d = line_d;
                    end else begin
                        state_d = ST_FILL_GAP;
                    end
                end else begin
                    state_d = ST_FILL_REQ;
                end
            end
            ST_FILL_GAP: begin
                state_d = ST_FILL_REQ;
                idx_d   = idx_q + IDX_W'(1);
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output look-ahead: decode the next state so every output leaves a flop.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        rd_d        = (state_d == ST_FILL_REQ);
        wr_d        = (state_d == ST_WB_REQ);
        rsp_valid_d = (state_d == ST_RESP);
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if (state_d == ST_WB_REQ) begin
            addr_d  = victim_base_d + ADDR_WIDTH'(idx_d) * WORD_BYTES;
            wdata_d = victim_data_d[idx_d];
        end else if (state_d == ST_FILL_REQ) begin
            addr_d = fill_base_d + ADDR_WIDTH'(idx_d) * WORD_BYTES;
        end else begin
            addr_d = addr_q;
        end
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            fill_base_q   <= '0;
            victim_base_q <= '0;
            victim_data_q <= '0;
            line_q        <= '0;
            rsp_data_q    <= '0;
            cmd_ready_q   <= 1'b1;
            rd_q          <= 1'b0;
            wr_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            fill_base_q   <= fill_base_d;
            victim_base_q <= victim_base_d;
            victim_data_q <= victim_data_d;
            line_q        <= line_d;
            rsp_data_q    <= rsp_data_d;
            cmd_ready_q   <= cmd_ready_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            rsp_valid_q   <= rsp_valid_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
        end
    end

    assign cmd_ready        = cmd_ready_q;
    assign l2_cache_read    = rd_q;
    assign l2_cache_write   = wr_q;
    assign rsp_valid        = rsp_valid_q;
    assign l2_cache_addr    = addr_q;
    assign l2_cache_data_in = wdata_q;
    assign rsp_data         = rsp_data_q;

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// Bench for l2_mem_ctrl: table of miss commands plus hand-written stall,
// reset and address-wrap sequences, checked against a scoreboard.
module tb_l2_mem_ctrl;
    import l2_mem_ctrl_pkg::*;

    localparam int WPL = 1 << WORD_OFFSET_W;

    typedef struct {
        logic         evict;
        logic [31:0]  fill_addr;
        logic [31:0]  victim_addr;
        logic [127:0] vdata;
        int           delay;
        logic [31:0]  rbase;
        int           lat;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } txn_t;

    typedef struct {
        logic [127:0] line;
        int           acc;
        int           lat;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_evict = 1'b0;
    logic [31:0]  cmd_fill_addr = 32'h0;
    logic [31:0]  cmd_victim_addr = 32'h0;
    logic [127:0] cmd_victim_data = 128'h0;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic [31:0]  l2_cache_addr;
    logic [31:0]  l2_cache_data_in;
    logic [31:0]  l2_cache_data_out = 32'h0;
    logic         l2_cache_read;
    logic         l2_cache_write;
    logic         l2_cache_ready = 1'b0;

    l2_mem_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_evict         (cmd_evict),
        .cmd_fill_addr     (cmd_fill_addr),
        .cmd_victim_addr   (cmd_victim_addr),
        .cmd_victim_data   (cmd_victim_data),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .l2_cache_addr     (l2_cache_addr),
        .l2_cache_data_in  (l2_cache_data_in),
        .l2_cache_data_out (l2_cache_data_out),
        .l2_cache_read     (l2_cache_read),
        .l2_cache_write    (l2_cache_write),
        .l2_cache_ready    (l2_cache_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    txn_t exp_txn[$];
    rsp_t exp_rsp[$];
    vec_t vecs[4];

    // memory model configuration
    int           mem_delay    = 0;
    int           stall_word   = -1;
    int           stall_cycles = 0;
    logic [31:0]  rbase        = 32'h0;

    // monitor state
    bit           rdy_drv    = 1'b0;
    int           wcnt       = 0;
    int           need       = 0;
    int           gap_st     = 0;
    bit           prev_stall = 1'b0;
    bit           prev_rsp   = 1'b0;
    logic         p_rd, p_wr;
    logic [31:0]  p_addr, p_wdata;
    int           rsp_seen   = 0;
    logic [127:0] last_line  = 128'h0;

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Memory responder followed by the protocol monitor, in one process so
    // the monitor always sees the ready value the DUT samples next edge.
    task automatic mem_mon();
        txn_t t;
        rsp_t r;
        logic strobe;
        forever begin
            @(negedge clk);
            if (rst) begin
                rdy_drv = 1'b0;
                wcnt    = 0;
            end else begin
                if (rdy_drv) begin
                    rdy_drv = 1'b0;
                    wcnt    = 0;
                end
                if (l2_cache_read || l2_cache_write) begin
                    need = (l2_cache_read && int'(l2_cache_addr[3:2]) == stall_word)
                           ? stall_cycles : mem_delay;
                    if (wcnt >= need) begin
                        rdy_drv           = 1'b1;
                        l2_cache_data_out = rbase + 32'(l2_cache_addr[3:2]);
                    end else begin
                        wcnt++;
                    end
                end
            end
            l2_cache_ready = rdy_drv;

            if (rst) begin
                gap_st     = 0;
                prev_stall = 1'b0;
                prev_rsp   = 1'b0;
            end else begin
                strobe = l2_cache_read || l2_cache_write;
                if (strobe)
                    check(!(l2_cache_read && l2_cache_write), "strobe_excl",
                          128'({l2_cache_read, l2_cache_write}), 128'h0);
                if (gap_st == 1) begin
                    check(!strobe, "gap_low", 128'({l2_cache_read, l2_cache_write}), 128'h0);
                    gap_st = 2;
                end else if (gap_st == 2) begin
                    check(strobe, "gap_one_cycle", 128'(strobe), 128'h1);
                    gap_st = 0;
                end
                if (prev_stall)
                    check(l2_cache_read === p_rd && l2_cache_write === p_wr &&
                          l2_cache_addr === p_addr &&
                          (!p_wr || l2_cache_data_in === p_wdata),
                          "stall_stable", 128'(l2_cache_addr), 128'(p_addr));
                prev_stall = strobe && !rdy_drv;
                p_rd    = l2_cache_read;
                p_wr    = l2_cache_write;
                p_addr  = l2_cache_addr;
                p_wdata = l2_cache_data_in;
                if (strobe && rdy_drv) begin
                    if (exp_txn.size() == 0) begin
                        check(1'b0, "txn_unexpected", 128'(l2_cache_addr), 128'h0);
                    end else begin
                        t = exp_txn.pop_front();
                        check(l2_cache_write === t.wr && l2_cache_read === !t.wr, "txn_kind",
                              128'({l2_cache_read, l2_cache_write}), 128'({!t.wr, t.wr}));
                        check(l2_cache_addr === t.addr, "txn_addr",
                              128'(l2_cache_addr), 128'(t.addr));
                        if (t.wr)
                            check(l2_cache_data_in === t.data, "txn_wdata",
                                  128'(l2_cache_data_in), 128'(t.data));
                        if (!t.last) gap_st = 1;
                    end
                end
                if (prev_rsp)
                    check(rsp_valid === 1'b0, "rsp_pulse", 128'(rsp_valid), 128'h0);
                prev_rsp = (rsp_valid === 1'b1);
                if (rsp_valid) begin
                    rsp_seen++;
                    if (exp_rsp.size() == 0) begin
                        check(1'b0, "rsp_unexpected", rsp_data, 128'h0);
                    end else begin
                        r = exp_rsp.pop_front();
                        check(rsp_data === r.line, "rsp_data", rsp_data, r.line);
                        check(cyc - r.acc == r.lat, "rsp_latency",
                              128'(cyc - r.acc), 128'(r.lat));
                        last_line = r.line;
                    end
                end
            end
        end
    endtask

    task automatic send(input logic ev, input logic [31:0] fa, input logic [31:0] va,
                        input logic [127:0] vd, input logic [31:0] rb, input int lat);
        logic [31:0]  fb, vb;
        logic [127:0] line;
        txn_t         t;
        rsp_t         r;
        int           k;
        fb = fa & 32'hFFFF_FFF0;
        vb = va & 32'hFFFF_FFF0;
        for (int i = 0; i < WPL; i++) begin
            if (ev) begin
                t.wr = 1'b1; t.addr = vb + 32'(4 * i);
                t.data = vd[32*i +: 32]; t.last = (i == WPL - 1);
                exp_txn.push_back(t);
            end
        end
        for (int i = 0; i < WPL; i++) begin
            t.wr = 1'b0; t.addr = fb + 32'(4 * i); t.data = 32'h0; t.last = (i == WPL - 1);
            exp_txn.push_back(t);
            line[32*i +: 32] = rb + 32'(i);
        end
        k = 0;
        while (cmd_ready !== 1'b1 && k < 100) begin
            @(negedge clk); #2;
            k++;
        end
        check(cmd_ready === 1'b1, "cmd_ready_wait", 128'(cmd_ready), 128'h1);
        cmd_evict = ev; cmd_fill_addr = fa; cmd_victim_addr = va; cmd_victim_data = vd;
        cmd_valid = 1'b1;
        r.line = line; r.acc = cyc; r.lat = lat;
        exp_rsp.push_back(r);
        @(negedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_rsp.size() != 0 && k < 300) begin
            @(negedge clk); #2;
            k++;
        end
        check(k < 300, "rsp_timeout", 128'(k), 128'd300);
        if (k >= 300) begin
            exp_txn.delete();
            exp_rsp.delete();
        end
        @(negedge clk); #2;
    endtask

    initial begin
        int k;
        int seen;
        vecs[0] = '{1'b0, 32'h0000_1004, 32'h0, 128'h0, 2, 32'h0000_00A0, 16};
        vecs[1] = '{1'b1, 32'h0000_3000, 32'h0000_2000,
                    128'h00000044_00000033_00000022_00000011, 0, 32'h5500_0000, 15};
        vecs[2] = '{1'b1, 32'h7777_7778, 32'h0000_4A3C,
                    128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 1, 32'hDEAD_0000, 23};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0, 128'h0, 0, 32'h1234_5678, 8};

        fork mem_mon(); join_none

        #1 rst = 1'b1;
        @(negedge clk); #2;
        check(l2_cache_read === 1'b0 && l2_cache_write === 1'b0, "rst_strobes",
              128'({l2_cache_read, l2_cache_write}), 128'h0);
        check(rsp_valid === 1'b0, "rst_rsp_valid", 128'(rsp_valid), 128'h0);
        check(l2_cache_addr === 32'h0 && l2_cache_data_in === 32'h0, "rst_addr_data",
              128'({l2_cache_addr, l2_cache_data_in}), 128'h0);
        check(rsp_data === 128'h0, "rst_rsp_data", rsp_data, 128'h0);
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk); #2;
        check(cmd_ready === 1'b1, "rst_cmd_ready", 128'(cmd_ready), 128'h1);

        foreach (vecs[v]) begin
            mem_delay = vecs[v].delay; stall_word = -1; rbase = vecs[v].rbase;
            send(vecs[v].evict, vecs[v].fill_addr, vecs[v].victim_addr,
                 vecs[v].vdata, vecs[v].rbase, vecs[v].lat);
            wait_done();
        end

        // back-pressure: word 2 of a fill held off for 20 cycles
        mem_delay = 0; stall_word = 2; stall_cycles = 20; rbase = 32'h5A5A_0000;
        send(1'b0, 32'h0000_5000, 32'h0, 128'h0, rbase, 28);
        k = 0;
        while (!(l2_cache_read === 1'b1 && l2_cache_addr === 32'h0000_5008) && k < 50) begin
            @(negedge clk); #2;
            k++;
        end
        check(k < 50, "stall_reach_word2", 128'(k), 128'd50);
        repeat (5) begin @(negedge clk); #2; end
        check(rsp_data === last_line, "rsp_hold", rsp_data, last_line);
        wait_done();
        stall_word = -1;

        // reset during the word-1 read beat
        mem_delay = 3; rbase = 32'h6600_0000;
        send(1'b0, 32'h0000_6000, 32'h0, 128'h0, rbase, 20);
        k = 0;
        while (!(l2_cache_read === 1'b1 && l2_cache_addr === 32'h0000_6004) && k < 50) begin
            @(negedge clk); #2;
            k++;
        end
        check(k < 50, "rst_reach_word1", 128'(k), 128'd50);
        seen = rsp_seen;
        rst = 1'b1;
        #1;
        check(l2_cache_read === 1'b0 && l2_cache_write === 1'b0, "rst_mid_strobes",
              128'({l2_cache_read, l2_cache_write}), 128'h0);
        exp_txn.delete();
        exp_rsp.delete();
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
        @(negedge clk); #2;
        check(cmd_ready === 1'b1, "rst_mid_cmd_ready", 128'(cmd_ready), 128'h1);
        repeat (12) begin @(negedge clk); #2; end
        check(rsp_seen == seen, "rst_no_rsp", 128'(rsp_seen), 128'(seen));

        // spurious ready in IDLE, then a fill at the top of the address space
        mem_delay = 0; rbase = 32'hF0F0_0000;
        l2_cache_ready = 1'b1;
        @(negedge clk); #2;
        check(cmd_ready === 1'b1 && l2_cache_read === 1'b0 && l2_cache_write === 1'b0,
              "idle_noise", 128'({cmd_ready, l2_cache_read, l2_cache_write}), 128'h4);
        send(1'b0, 32'hFFFF_FFF0, 32'h0, 128'h0, rbase, 8);
        wait_done();

        check(exp_txn.size() == 0, "txn_drained", 128'(exp_txn.size()), 128'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l2_mem_ctrl.md
L2_MEM_CTRL -- requirements
Module: l2_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one memory word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: byte address width.
REQ-003 SHALL have parameter WORDS_PER_LINE, default 4: power of two, at least 2; words per cache line.
REQ-004 SHALL have ports `clk`, `rst` and `cmd_*`:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  L2 miss command present.
- `cmd_ready`  out  1  controller idle; command accepted when `cmd_valid` and `cmd_ready` are both high.
- `cmd_evict`  in  1  dirty victim; write the victim line back before the fill.
- `cmd_fill_addr`  in  ADDR_WIDTH  miss address.
- `cmd_victim_addr`  in  ADDR_WIDTH  victim address; used only when `cmd_evict` is high.
- `cmd_victim_data`  in  DATA_WIDTH*WORDS_PER_LINE  victim line; word 0 in the LSBs.
REQ-005 SHALL have ports `rsp_*` and `l2_cache_*`:
- `rsp_valid`  out  1  one-cycle pulse; fill line available.
- `rsp_data`  out  DATA_WIDTH*WORDS_PER_LINE  filled line; word 0 in the LSBs.
- `l2_cache_addr`  out  ADDR_WIDTH  memory word address.
- `l2_cache_data_in`  out  DATA_WIDTH  write data to memory.
- `l2_cache_data_out`  in  DATA_WIDTH  read data from memory.
- `l2_cache_read`  out  1  read strobe.
- `l2_cache_write`  out  1  write strobe.
- `l2_cache_ready`  in  1  memory completes the current word.

Function
REQ-006 SHALL implement FSM states IDLE, WB_REQ, WB_GAP, FILL_REQ, FILL_GAP, RESP.
REQ-007 SHALL drive `cmd_ready` high only in IDLE.
REQ-008 SHALL, on command accept, register all cmd_* inputs and force the low log2(WORDS_PER_LINE*DATA_WIDTH/8) bits of both addresses to zero.
REQ-009 SHALL move IDLE to WB_REQ if `cmd_evict`=1, else to FILL_REQ.
REQ-010 SHALL, in WB_REQ, drive `l2_cache_write`=1, `l2_cache_addr`=victim base+idx*(DATA_WIDTH/8) and `l2_cache_data_in`=victim word idx.
REQ-011 SHALL, in FILL_REQ, drive `l2_cache_read`=1 and `l2_cache_addr`=fill base+idx*(DATA_WIDTH/8).
REQ-012 SHALL, in FILL_REQ, capture `l2_cache_data_out` into word idx of the line buffer on the cycle `l2_cache_ready`=1.
REQ-013 SHALL complete a word handshake on a cycle where the strobe and `l2_cache_ready` are both high; strobe, address and data SHALL stay stable until that cycle.
REQ-014 SHALL, after each completed word, go to the matching GAP state for exactly one cycle with both strobes low, then return to the REQ state with idx+1.
REQ-015 SHALL, after the last word (idx=WORDS_PER_LINE-1), skip the gap: WB_REQ goes to FILL_REQ with idx=0, and FILL_REQ goes to RESP.
REQ-016 SHALL, in RESP, pulse `rsp_valid` for one cycle with `rsp_data` valid, then return to IDLE; `rsp_data` SHALL hold until the next fill completes.
REQ-017 SHALL never assert `l2_cache_read` and `l2_cache_write` in the same cycle.
REQ-018 SHALL ignore `l2_cache_ready` in IDLE, GAP and RESP states.
REQ-019 SHALL wait indefinitely in a REQ state while `l2_cache_ready`=0 (no timeout).
REQ-020 SHALL let address arithmetic wrap modulo 2^ADDR_WIDTH.
REQ-021 SHALL have minimum latency, accept to `rsp_valid`, with `l2_cache_ready` high on every strobe cycle:
- fill only: 2*WORDS_PER_LINE cycles.
- evict plus fill: 4*WORDS_PER_LINE-1 cycles.

Reset
REQ-022 SHALL, while `rst`=1, immediately force state IDLE, idx=0, and `l2_cache_read`, `l2_cache_write` and `rsp_valid` to 0.
REQ-023 SHALL reset `l2_cache_addr`, `l2_cache_data_in`, `rsp_data` and all captured registers to 0.
REQ-024 SHALL, on reset asserted mid-transaction, drop the transaction with no response; `cmd_ready`=1 on the first cycle after `rst` deasserts.

Structure
REQ-025 SHALL place the FSM state enum and the word-offset width constant in the shared cache package, alongside DATA_WIDTH/ADDR_WIDTH defaults.
REQ-026 SHALL be a single module; the word-beat counter is inline, with no sub-module.

Verification
REQ-027 SHALL cover a fill with no evict:
- stimulus: addr 0x1004, memory returns 0xA0..0xA3 with ready after 2 cycles.
- required: reads at 0x1000, 0x1004, 0x1008, 0x100C; rsp_data=0x000000A3_000000A2_000000A1_000000A0.
REQ-028 SHALL cover an evict plus fill:
- stimulus: victim 0x2000 with data 0x11..0x44, fill 0x3000, memory ready immediately.
- required: four writes at 0x2000..0x200C carrying 0x11, 0x22, 0x33, 0x44, then four reads at 0x3000..; rsp_valid 15 cycles after accept.
REQ-029 SHALL cover back-pressure:
- stimulus: l2_cache_ready held low 20 cycles on word 2.
- required: addr and strobe stable across all 20 cycles; no gap or skipped word.
REQ-030 SHALL cover reset mid-transaction:
- stimulus: rst asserted during the FILL_REQ beat for word 1.
- required: strobes low in the same cycle; no rsp_valid; cmd_ready=1 on the first cycle after rst deasserts.
REQ-031 SHALL cover address wrap and idle noise:
- stimulus: fill addr 0xFFFFFFF0; a spurious ready pulse while IDLE.
- required: addresses 0xFFFFFFF0..0xFFFFFFFC; the idle ready pulse is ignored.
REQ-032 SHALL, across all scenarios, check that read and write strobes are never high together and that each gap is exactly one cycle with both strobes low.
